// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG sequencing controller.
//   - state_t     : controller FSM states
//   - *_DEF       : default parameter values for the controller
//   - cnt_w()     : width of a counter that must hold values 0..max_val
package trng_pkg;

    localparam int WIDTH_DEF      = 8;
    localparam int OUT_W_DEF      = 32;
    localparam int WARMUP_CYC_DEF = 64;
    localparam int RCT_LIMIT_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_SAMPLE,
        ST_HOLD,
        ST_FAIL
    } state_t;

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/trng_rct_health.sv
// Repetition-count health test on a stream of single entropy bits.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : bit_in is a valid sample this cycle
//   clr        : forget run history (takes priority over en)
//   bit_in     : folded entropy bit
//   fail       : combinational pulse, high on the sample that makes the run
//                of identical bits reach RCT_LIMIT
module trng_rct_health
    import trng_pkg::*;
#(
    parameter int RCT_LIMIT = RCT_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic bit_in,
    output logic fail
);

    localparam int CNT_W = cnt_w(RCT_LIMIT);

    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // With cnt_q == 0 the first bit always yields a run length of 1,
    // whichever value prev_q happens to hold.
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        fail   = 1'b0;
        if (clr) begin
            prev_d = 1'b0;
            cnt_d  = '0;
        end else if (en) begin
            prev_d = bit_in;
            if (bit_in == prev_q)
                cnt_d = cnt_q + CNT_W'(1);
            else
                cnt_d = CNT_W'(1);
            fail = (cnt_d == CNT_W'(RCT_LIMIT));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/trng_ctrl.sv
// Sequencing controller for the ring-oscillator entropy array.
// Enables the oscillators, waits out a warm-up period, folds each raw sample
// to one bit, debiases with a von Neumann extractor, health-checks with a
// repetition-count test, and packs OUT_W-bit words for a valid/ready consumer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : level request to produce entropy
//   clear_fail   : pulse, clears the sticky health failure
//   raw_in       : registered sample bus from the RO array
//   ro_en        : oscillator enable
//   out_valid    : out_data holds a fresh word
//   out_ready    : consumer accepts the word
//   out_data     : debiased random word (first extracted bit in the MSB)
//   busy         : controller not idle
//   health_fail  : sticky health-test failure
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int WARMUP_CYC = WARMUP_CYC_DEF,
    parameter int RCT_LIMIT  = RCT_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear_fail,
    input  logic [WIDTH-1:0] raw_in,
    output logic             ro_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy,
    output logic             health_fail
);

    localparam int BIT_W  = cnt_w(OUT_W);
    localparam int WARM_W = cnt_w(WARMUP_CYC);

    state_t            state_q, state_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              phase_q, phase_d;   // 1 = first bit of a pair is stored
    logic              first_q, first_d;
    logic              valid_q, valid_d;
    logic              fail_q, fail_d;

    logic              fold_bit;
    logic              sampling;
    logic              pair_done;
    logic              word_done;
    logic              rct_fail;
    logic [OUT_W-1:0]  acc_shift;

    assign fold_bit  = ^raw_in;
    assign sampling  = (state_q == ST_SAMPLE);
    // Second bit of an unequal pair: the stored first bit is the output bit.
    assign pair_done = phase_q && (first_q != fold_bit);
    assign word_done = sampling && pair_done && (bitcnt_q == BIT_W'(OUT_W - 1));
    assign acc_shift = {acc_q[OUT_W-2:0], first_q};

    // Run history is held clear for the whole warm-up, so every SAMPLE
    // entry from WARMUP starts a fresh test; HOLD keeps the history.
    trng_rct_health #(
        .RCT_LIMIT (RCT_LIMIT)
    ) u_rct (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (sampling),
        .clr    (state_q == ST_WARMUP),
        .bit_in (fold_bit),
        .fail   (rct_fail)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    // Next-state logic. In SAMPLE a health failure outranks word completion,
    // which in turn outranks a dropped start.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WARMUP;
                    warm_d  = WARM_W'(WARMUP_CYC - 1);
                end
            end
            ST_WARMUP: begin
                if (!start)
                    state_d = ST_IDLE;
                else if (warm_q == '0)
                    state_d = ST_SAMPLE;
                else
                    warm_d = warm_q - WARM_W'(1);
            end
            ST_SAMPLE: begin
                if (rct_fail)
                    state_d = ST_FAIL;
                else if (word_done)
                    state_d = ST_HOLD;
                else if (!start)
                    state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (valid_q && out_ready)
                    state_d = start ? ST_SAMPLE : ST_IDLE;
            end
            ST_FAIL: begin
                if (clear_fail)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: pairing, packing, word hand-off and the sticky failure flag.
    always_comb begin
        acc_d    = acc_q;
        bitcnt_d = bitcnt_q;
        phase_d  = phase_q;
        first_d  = first_q;
        data_d   = data_q;
        valid_d  = valid_q;
        fail_d   = fail_q;

        if (sampling) begin
            if (!phase_q) begin
                first_d = fold_bit;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (pair_done) begin
                    acc_d    = acc_shift;
                    bitcnt_d = bitcnt_q + BIT_W'(1);
                end
            end
            // Any exit from SAMPLE drops the partial word.
            if (state_d != ST_SAMPLE) begin
                acc_d    = '0;
                bitcnt_d = '0;
                phase_d  = 1'b0;
                if (state_d == ST_HOLD) begin
                    data_d  = acc_shift;
                    valid_d = 1'b1;
                end
                if (state_d == ST_FAIL)
                    fail_d = 1'b1;
            end
        end

        if (state_q == ST_HOLD && valid_q && out_ready)
            valid_d = 1'b0;
        if (state_q == ST_FAIL && clear_fail)
            fail_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            bitcnt_q <= '0;
            phase_q  <= 1'b0;
            first_q  <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            bitcnt_q <= bitcnt_d;
            phase_q  <= phase_d;
            first_q  <= first_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            fail_q   <= fail_d;
        end
    end

    // Outputs
    always_comb begin
        ro_en       = (state_q == ST_WARMUP) || (state_q == ST_SAMPLE) ||
                      (state_q == ST_HOLD);
        busy        = (state_q != ST_IDLE);
        out_valid   = valid_q;
        out_data    = data_q;
        health_fail = fail_q;
    end

endmodule

// File: tb/tb_trng_ctrl.sv
// Self-checking bench for trng_ctrl: a vector table of whole-run scenarios,
// hand-written multi-cycle sequences, and randomized traffic, all compared
// every cycle against a behavioural model built from the controller rules.
module tb_trng_ctrl;

    localparam int WIDTH      = 8;
    localparam int OUT_W      = 32;
    localparam int WARMUP_CYC = 64;
    localparam int RCT_LIMIT  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             clear_fail;
    logic [WIDTH-1:0] raw_in;
    logic             ro_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             busy;
    logic             health_fail;

    int n_tests = 0;
    int n_fail  = 0;

    trng_ctrl #(
        .WIDTH      (WIDTH),
        .OUT_W      (OUT_W),
        .WARMUP_CYC (WARMUP_CYC),
        .RCT_LIMIT  (RCT_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .clear_fail  (clear_fail),
        .raw_in      (raw_in),
        .ro_en       (ro_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_WARM = 1, M_SAMP = 2, M_HOLD = 3, M_BAD = 4;
    int               m_mode;
    int               m_warm;     // cycles spent warming so far
    int               m_run;      // length of current run of equal bits (0 = none yet)
    bit               m_prev;
    bit               m_pend[$];  // folded bits awaiting a partner
    bit               m_word[$];  // debiased bits of the word being built
    logic             m_valid;
    logic [OUT_W-1:0] m_data;
    logic             m_hf;

    function automatic void model_reset();
        m_mode = M_IDLE; m_warm = 0; m_run = 0; m_prev = 0;
        m_pend.delete(); m_word.delete();
        m_valid = 0; m_data = '0; m_hf = 0;
    endfunction

    function automatic void model_step();
        bit b;
        case (m_mode)
            M_IDLE: if (start) begin m_mode = M_WARM; m_warm = 0; end
            M_WARM: begin
                if (!start) m_mode = M_IDLE;
                else begin
                    m_warm++;
                    if (m_warm == WARMUP_CYC) begin
                        m_mode = M_SAMP; m_run = 0;
                        m_pend.delete(); m_word.delete();
                    end
                end
            end
            M_SAMP: begin
                b = ^raw_in;
                if (m_run > 0 && b == m_prev) m_run++; else m_run = 1;
                m_prev = b;
                if (m_run == RCT_LIMIT) begin
                    m_mode = M_BAD; m_hf = 1;
                    m_pend.delete(); m_word.delete();
                end else begin
                    m_pend.push_back(b);
                    if (m_pend.size() == 2) begin
                        if (m_pend[0] != m_pend[1]) m_word.push_back(m_pend[0]);
                        m_pend.delete();
                    end
                    if (m_word.size() == OUT_W) begin
                        for (int i = 0; i < OUT_W; i++) m_data[OUT_W-1-i] = m_word[i];
                        m_valid = 1; m_mode = M_HOLD;
                        m_pend.delete(); m_word.delete();
                    end else if (!start) begin
                        m_mode = M_IDLE;
                        m_pend.delete(); m_word.delete();
                    end
                end
            end
            M_HOLD: if (out_ready) begin m_valid = 0; m_mode = start ? M_SAMP : M_IDLE; end
            M_BAD:  if (clear_fail) begin m_mode = M_IDLE; m_hf = 0; end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic e_ro;
        e_ro = (m_mode == M_WARM) || (m_mode == M_SAMP) || (m_mode == M_HOLD);
        chk("model ro_en", 32'(ro_en), 32'(e_ro));
        chk("model busy", 32'(busy), 32'(m_mode != M_IDLE));
        chk("model out_valid", 32'(out_valid), 32'(m_valid));
        chk("model out_data", out_data, m_data);
        chk("model health_fail", 32'(health_fail), 32'(m_hf));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 0; start = 1; clear_fail = 0; out_ready = 0; raw_in = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_model();
        start = 0;
        rst_n = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        start;
        logic [7:0]  raw_even;
        logic [7:0]  raw_odd;
        logic        ready;
        int          ncyc;
        logic        exp_ro_en;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_busy;
        logic        exp_hf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 10,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1,   1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h00, 8'h00, 1'b0, 64,  1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h00, 8'h01, 1'b0, 128, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h00, 8'h01, 1'b0, 129, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h01, 8'h00, 1'b0, 129, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 8'h00, 8'h03, 1'b0, 80,  1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 8'h03, 1'b0, 81,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 8'h01, 8'h01, 1'b0, 81,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 8'h00, 8'h01, 1'b1, 130, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 8'h01, 1'b0, 300, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'hFF, 8'h7F, 1'b0, 129, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};

        rst_n = 0; start = 0; clear_fail = 0; out_ready = 0; raw_in = '0;

        for (int v = 0; v < 12; v++) begin
            do_reset();
            start     = vecs[v].start;
            out_ready = vecs[v].ready;
            for (int k = 0; k < vecs[v].ncyc; k++) begin
                raw_in = (k % 2 == 1) ? vecs[v].raw_odd : vecs[v].raw_even;
                cycle();
            end
            chk($sformatf("vec%0d ro_en", v), 32'(ro_en), 32'(vecs[v].exp_ro_en));
            chk($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("vec%0d out_data", v), out_data, vecs[v].exp_data);
            chk($sformatf("vec%0d busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            chk($sformatf("vec%0d health_fail", v), 32'(health_fail), 32'(vecs[v].exp_hf));
            $display("[TB] vector %0d: %0d cycles, valid=%0b data=%h hf=%0b", v,
                     vecs[v].ncyc, out_valid, out_data, health_fail);
        end

        // Backpressure; start dropped on the completing edge and held low in HOLD.
        do_reset();
        start = 1; out_ready = 0;
        for (int k = 0; k < 129; k++) begin
            raw_in = (k % 2 == 1) ? 8'h01 : 8'h00;
            if (k == 128) start = 0;
            cycle();
        end
        chk("bp word valid", 32'(out_valid), 32'd1);
        chk("bp word data", out_data, 32'hFFFF_FFFF);
        for (int k = 0; k < 20; k++) begin
            raw_in = 8'($urandom);
            cycle();
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold data", out_data, 32'hFFFF_FFFF);
            chk("bp hold ro_en", 32'(ro_en), 32'd1);
        end
        out_ready = 1;
        cycle();
        chk("bp done valid", 32'(out_valid), 32'd0);
        chk("bp done busy", 32'(busy), 32'd0);
        chk("bp done ro_en", 32'(ro_en), 32'd0);
        $display("[TB] backpressure sequence: valid=%0b busy=%0b ro_en=%0b", out_valid, busy, ro_en);

        // Health failure, start ignored in failure, clear_fail with start held.
        do_reset();
        start = 1; out_ready = 1; raw_in = 8'h01;
        repeat (81) cycle();
        chk("hf flag", 32'(health_fail), 32'd1);
        chk("hf ro_en", 32'(ro_en), 32'd0);
        chk("hf valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 10; k++) begin
            raw_in = 8'($urandom);
            cycle();
            chk("hf stuck busy", 32'(busy), 32'd1);
            chk("hf stuck ro_en", 32'(ro_en), 32'd0);
        end
        clear_fail = 1;
        cycle();
        clear_fail = 0;
        chk("hf cleared flag", 32'(health_fail), 32'd0);
        chk("hf cleared busy", 32'(busy), 32'd0);
        cycle();
        chk("hf restart ro_en", 32'(ro_en), 32'd1);
        chk("hf restart busy", 32'(busy), 32'd1);
        clear_fail = 1;   // outside failure: must do nothing
        cycle();
        clear_fail = 0;
        chk("stray clear busy", 32'(busy), 32'd1);
        chk("stray clear ro_en", 32'(ro_en), 32'd1);
        $display("[TB] health sequence: hf=%0b busy=%0b ro_en=%0b", health_fail, busy, ro_en);

        // Asynchronous reset between clock edges.
        repeat (5) cycle();
        #2;
        rst_n = 0;
        #1;
        chk("async rst ro_en", 32'(ro_en), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        $display("[TB] async reset: ro_en=%0b busy=%0b", ro_en, busy);
        do_reset();

        // Randomized traffic against the model.
        for (int s = 0; s < 30; s++) begin
            int   len, mode, rdy_pct;
            logic lvl;
            len     = $urandom_range(40, 400);
            mode    = $urandom_range(0, 2);
            rdy_pct = $urandom_range(10, 90);
            lvl     = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < len; k++) begin
                start      = ($urandom_range(0, 199) == 0) ? ~lvl : lvl;
                out_ready  = ($urandom_range(0, 99) < rdy_pct);
                clear_fail = ($urandom_range(0, 49) == 0);
                case (mode)
                    0: raw_in = 8'($urandom);
                    1: raw_in = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h01;
                    default: raw_in = ($urandom_range(0, 7) == 0) ? 8'($urandom) :
                                      ((k % 2 == 1) ? 8'h01 : 8'h00);
                endcase
                cycle();
            end
            $display("[TB] random segment %0d: mode=%0d len=%0d start=%0b valid=%0b hf=%0b",
                     s, mode, len, lvl, out_valid, health_fail);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
